wb_dest_arbiter: RTL and testbench

Writeback-port controller for the register file in the pipelined MIPS datapath. It shares the single register-file write port between the main pipeline's WB stage and a multi-cycle unit (SAD/MUL result path), which delivers results through a 2-entry holding buffer. It produces the RegDst-style destination select (rt / rd / $31), the write address, data and enable, and a stall request when the buffered unit has been starved too long. All register-file write outputs are registered.

---
 rtl/wb_dest_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_dest_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dest_arbiter.sv
// Register-file write-port arbiter: the WB stage and a 2-entry multi-cycle result buffer share one port.
// Define WBARB_STARVE_EN to add the starvation counter and the FORCE state that stalls WB for one cycle.
module wb_dest_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        pipe_valid,
  input  logic [1:0]  pipe_regdst,
  input  logic [4:0]  pipe_rt,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mc_valid,
  input  logic [4:0]  mc_dest,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  output logic        pipe_stall,
  output logic [1:0]  dst_sel,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  if (CNT_W < $clog2(STARVE_LIMIT + 1)) begin : gCntTooNarrow
    $error("CNT_W too narrow to hold STARVE_LIMIT");
  end

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } entryT;

  entryT       bufMem [2];
  entryT       nxtMem [2];
  logic [1:0]  count, nxtCount;
  logic        pipeGrant, bufGrant, enq, keep0, keep1;
  logic [4:0]  pipeAddr;
  logic [1:0]  pipeSel;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pipeSel  = 2'd2;
    pipeAddr = 5'd31;
    case (pipe_regdst)
      2'd0: begin pipeSel = 2'd0; pipeAddr = pipe_rt; end
      2'd1: begin pipeSel = 2'd1; pipeAddr = pipe_rd; end
      default: ;
    endcase
  end

  assign mc_ready = (count < 2'd2);
  // Results for $0 complete the handshake but are dropped.
  assign enq      = mc_valid && mc_ready && (mc_dest != 5'd0);

`ifdef WBARB_STARVE_EN
  typedef enum logic {NORMAL, FORCE} stateT;

  stateT            state, nxtState;
  logic [CNT_W-1:0] starveCnt, nxtStarveCnt;

  always_comb begin
    pipeGrant = 1'b0;
    bufGrant  = 1'b0;
    if (state == FORCE)  bufGrant  = (count != 2'd0);
    else if (pipe_valid) pipeGrant = 1'b1;
    else                 bufGrant  = (count != 2'd0);
  end

  assign pipe_stall = (state == FORCE);

  // A buffer emptied by squashes is no longer starving, so look at the post-update count.
  always_comb begin
    nxtStarveCnt = '0;
    nxtState     = NORMAL;
    if (state == NORMAL && count != 2'd0 && !bufGrant && nxtCount != 2'd0)
      nxtStarveCnt = starveCnt + 1'b1;
    if (nxtStarveCnt == CNT_W'(STARVE_LIMIT))
      nxtState = FORCE;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= NORMAL;
      starveCnt <= '0;
    end else begin
      state     <= nxtState;
      starveCnt <= nxtStarveCnt;
    end
  end
`else
  assign pipeGrant  = pipe_valid;
  assign bufGrant   = !pipe_valid && (count != 2'd0);
  assign pipe_stall = 1'b0;
`endif

  // Drop the popped head and any entry overwritten by the granted WB write, compact, then append.
  always_comb begin
    nxtMem   = bufMem;
    nxtCount = 2'd0;
    keep0    = (count != 2'd0) && !bufGrant && !(pipeGrant && bufMem[0].dest == pipeAddr);
    keep1    = (count == 2'd2) && !(pipeGrant && bufMem[1].dest == pipeAddr);
    if (keep0) begin
      nxtMem[0] = bufMem[0];
      nxtCount  = 2'd1;
    end
    if (keep1) begin
      nxtMem[nxtCount[0]] = bufMem[1];
      nxtCount            = nxtCount + 2'd1;
    end
    if (enq) begin
      nxtMem[nxtCount[0]] = '{dest: mc_dest, data: mc_data};
      nxtCount            = nxtCount + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) count <= 2'd0;
    else      count <= nxtCount;
  end

  // NOTE: the buffer storage has no reset; count alone marks entries valid, so reset still discards them.
  always_ff @(posedge Clk) begin
    bufMem <= nxtMem;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
      dst_sel  <= 2'd0;
    end else if (pipeGrant) begin
      rf_we    <= (pipeAddr != 5'd0);
      rf_waddr <= pipeAddr;
      rf_wdata <= pipe_data;
      dst_sel  <= pipeSel;
    end else if (bufGrant) begin
      rf_we    <= 1'b1;
      rf_waddr <= bufMem[0].dest;
      rf_wdata <= bufMem[0].data;
      dst_sel  <= 2'd3;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_dest_arbiter.sv
// Directed bench for wb_dest_arbiter: expected writes are queued as stimulus is driven and
// compared on the cycle after. Starvation steps follow whether WBARB_STARVE_EN is defined.
module tb_wb_dest_arbiter;

  logic        Clk, Rst;
  logic        pipe_valid;
  logic [1:0]  pipe_regdst;
  logic [4:0]  pipe_rt, pipe_rd;
  logic [31:0] pipe_data;
  logic        mc_valid;
  logic [4:0]  mc_dest;
  logic [31:0] mc_data;
  logic        mc_ready, pipe_stall, rf_we;
  logic [1:0]  dst_sel;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  typedef struct packed {
    logic [1:0]  sel;
    logic [4:0]  addr;
    logic [31:0] data;
  } wrT;

  wrT expQ[$];
  int checks   = 0;
  int failures = 0;

  wb_dest_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .Clk(Clk), .Rst(Rst),
    .pipe_valid(pipe_valid), .pipe_regdst(pipe_regdst), .pipe_rt(pipe_rt), .pipe_rd(pipe_rd),
    .pipe_data(pipe_data), .mc_valid(mc_valid), .mc_dest(mc_dest), .mc_data(mc_data),
    .mc_ready(mc_ready), .pipe_stall(pipe_stall), .dst_sel(dst_sel), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setPipe(input logic v, input logic [1:0] rdst, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] d);
    pipe_valid = v; pipe_regdst = rdst; pipe_rt = rt; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic setMc(input logic v, input logic [4:0] dst, input logic [31:0] d);
    mc_valid = v; mc_dest = dst; mc_data = d;
  endtask

  task automatic expWrite(input logic [1:0] sel, input logic [4:0] addr, input logic [31:0] d);
    expQ.push_back('{sel: sel, addr: addr, data: d});
  endtask

  // Advance one edge; a queued expectation must appear now, otherwise rf_we must stay low.
  task automatic tick(input string tag);
    wrT  e;
    logic expW;
    @(posedge Clk);
    #1;
    expW = (expQ.size() != 0);
    chk({tag, "_we"}, {31'd0, rf_we}, {31'd0, expW});
    if (expW) begin
      e = expQ.pop_front();
      chk({tag, "_sel"},  {30'd0, dst_sel},  {30'd0, e.sel});
      chk({tag, "_addr"}, {27'd0, rf_waddr}, {27'd0, e.addr});
      chk({tag, "_data"}, rf_wdata, e.data);
    end
  endtask

  initial begin
    logic [4:0] decAddr [4];
    logic [1:0] decSel  [4];
    decAddr = '{5'd8, 5'd9, 5'd31, 5'd31};
    decSel  = '{2'd0, 2'd1, 2'd2, 2'd2};

    Rst = 1'b0;
    setPipe(1'b0, 2'd0, 5'd0, 5'd0, 32'd0);
    setMc(1'b0, 5'd0, 32'd0);

    // Reset state
    #12;
    chk("rst_we",    {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_sel",   {30'd0, dst_sel}, 32'd0);
    chk("rst_ready", {31'd0, mc_ready}, 32'd1);
    chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    tick("idle0");
    tick("idle1");

    // RegDst decode
    for (int r = 0; r < 4; r++) begin
      setPipe(1'b1, 2'(r), 5'd8, 5'd9, 32'h1234 + 32'(r));
      expWrite(decSel[r], decAddr[r], 32'h1234 + 32'(r));
      tick($sformatf("regdst%0d", r));
    end
    // Resolved address 0 is granted without a write
    setPipe(1'b1, 2'd0, 5'd0, 5'd3, 32'hDEAD);
    tick("zero_addr");
    setPipe(1'b0, 2'd0, 5'd0, 5'd0, 32'd0);
    tick("idle2");

    // Buffer fill while the pipeline writes every cycle
    setPipe(1'b1, 2'd1, 5'd0, 5'd20, 32'h2000);
    setMc(1'b1, 5'd5, 32'h55);
    chk("fill0_ready", {31'd0, mc_ready}, 32'd1);
    expWrite(2'd1, 5'd20, 32'h2000);
    tick("fill0");
    setPipe(1'b1, 2'd1, 5'd0, 5'd21, 32'h2001);
    setMc(1'b1, 5'd6, 32'h66);
    chk("fill1_ready", {31'd0, mc_ready}, 32'd1);
    expWrite(2'd1, 5'd21, 32'h2001);
    tick("fill1");
    setPipe(1'b1, 2'd1, 5'd0, 5'd22, 32'h2002);
    setMc(1'b1, 5'd7, 32'h77);
    chk("full_ready", {31'd0, mc_ready}, 32'd0);
    chk("full_stall", {31'd0, pipe_stall}, 32'd0);
    expWrite(2'd1, 5'd22, 32'h2002);
    tick("fill2");
    // Drain: dest 7 waits until a slot frees
    setPipe(1'b0, 2'd0, 5'd0, 5'd0, 32'd0);
    chk("drain0_ready", {31'd0, mc_ready}, 32'd0);
    expWrite(2'd3, 5'd5, 32'h55);
    tick("drain0");
    chk("drain1_ready", {31'd0, mc_ready}, 32'd1);
    expWrite(2'd3, 5'd6, 32'h66);
    tick("drain1");
    setMc(1'b0, 5'd0, 32'd0);
    expWrite(2'd3, 5'd7, 32'h77);
    tick("drain2");
    tick("drained");

    // Starvation: buffer holds dest 5, pipeline valid every cycle
    setMc(1'b1, 5'd5, 32'h5555);
    tick("starve_load");
    setMc(1'b0, 5'd0, 32'd0);
`ifdef WBARB_STARVE_EN
    for (int k = 0; k < 4; k++) begin
      setPipe(1'b1, 2'd1, 5'd0, 5'(12 + k), 32'h3000 + 32'(k));
      chk($sformatf("starve_norm%0d_stall", k), {31'd0, pipe_stall}, 32'd0);
      expWrite(2'd1, 5'(12 + k), 32'h3000 + 32'(k));
      tick($sformatf("starve_norm%0d", k));
    end
    setPipe(1'b1, 2'd1, 5'd0, 5'd16, 32'h3004);
    chk("force_stall", {31'd0, pipe_stall}, 32'd1);
    expWrite(2'd3, 5'd5, 32'h5555);
    tick("force");
    chk("after_force_stall", {31'd0, pipe_stall}, 32'd0);
    expWrite(2'd1, 5'd16, 32'h3004);
    tick("replay");
`else
    for (int k = 0; k < 6; k++) begin
      setPipe(1'b1, 2'd1, 5'd0, 5'(12 + k), 32'h3000 + 32'(k));
      chk($sformatf("hold%0d_stall", k), {31'd0, pipe_stall}, 32'd0);
      expWrite(2'd1, 5'(12 + k), 32'h3000 + 32'(k));
      tick($sformatf("hold%0d", k));
    end
    setPipe(1'b0, 2'd0, 5'd0, 5'd0, 32'd0);
    expWrite(2'd3, 5'd5, 32'h5555);
    tick("late_drain");
`endif
    setPipe(1'b0, 2'd0, 5'd0, 5'd0, 32'd0);
    tick("starve_idle");

    // Conflict squash: single entry
    setMc(1'b1, 5'd10, 32'hAAAA);
    tick("sq_load");
    setMc(1'b0, 5'd0, 32'd0);
    setPipe(1'b1, 2'd1, 5'd0, 5'd10, 32'hBBBB);
    expWrite(2'd1, 5'd10, 32'hBBBB);
    tick("sq_pipe");
    setPipe(1'b0, 2'd0, 5'd0, 5'd0, 32'd0);
    chk("sq_ready", {31'd0, mc_ready}, 32'd1);
    tick("sq_empty");

    // Conflict squash of the head: the tail entry closes the gap
    setPipe(1'b1, 2'd1, 5'd0, 5'd1, 32'h4001);
    setMc(1'b1, 5'd11, 32'h1111);
    expWrite(2'd1, 5'd1, 32'h4001);
    tick("sq2_a");
    setPipe(1'b1, 2'd1, 5'd0, 5'd2, 32'h4002);
    setMc(1'b1, 5'd12, 32'h2222);
    expWrite(2'd1, 5'd2, 32'h4002);
    tick("sq2_b");
    setMc(1'b0, 5'd0, 32'd0);
    setPipe(1'b1, 2'd1, 5'd0, 5'd11, 32'hCCCC);
    chk("sq2_full", {31'd0, mc_ready}, 32'd0);
    expWrite(2'd1, 5'd11, 32'hCCCC);
    tick("sq2_pipe");
    setPipe(1'b0, 2'd0, 5'd0, 5'd0, 32'd0);
    chk("sq2_ready", {31'd0, mc_ready}, 32'd1);
    expWrite(2'd3, 5'd12, 32'h2222);
    tick("sq2_drain");
    tick("sq2_empty");

    // Reset mid-drain discards both buffered entries
    setPipe(1'b1, 2'd1, 5'd0, 5'd1, 32'h5001);
    setMc(1'b1, 5'd13, 32'h1313);
    expWrite(2'd1, 5'd1, 32'h5001);
    tick("rd_a");
    setPipe(1'b1, 2'd1, 5'd0, 5'd2, 32'h5002);
    setMc(1'b1, 5'd14, 32'h1414);
    expWrite(2'd1, 5'd2, 32'h5002);
    tick("rd_b");
    setMc(1'b0, 5'd0, 32'd0);
    setPipe(1'b0, 2'd0, 5'd0, 5'd0, 32'd0);
    chk("rd_full", {31'd0, mc_ready}, 32'd0);
    Rst = 1'b0;
    #1;
    chk("rd_rst_ready", {31'd0, mc_ready}, 32'd1);
    chk("rd_rst_stall", {31'd0, pipe_stall}, 32'd0);
    chk("rd_rst_we",    {31'd0, rf_we}, 32'd0);
    tick("rd_in_rst");
    Rst = 1'b1;
    tick("rd_post0");
    tick("rd_post1");
    tick("rd_post2");
    chk("rd_ready", {31'd0, mc_ready}, 32'd1);
    chk("queue_empty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
